// File: rtl/i2c_slave.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP detection,
// address decode with ACK, write-byte delivery and read-byte serving.
// SDA is open-drain: the block only pulls low or releases.
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_req,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       busy,
    output logic       error_slave
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] WR_DATA  = 3'd3;
    localparam logic [2:0] WR_ACK   = 3'd4;
    localparam logic [2:0] RD_DATA  = 3'd5;
    localparam logic [2:0] RD_ACK   = 3'd6;
    localparam logic [2:0] IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;

    logic                   scl_rise_c;
    logic                   scl_fall_c;
    logic                   start_c;
    logic                   stop_c;

    logic [2:0]             state;
    logic [2:0]             state_n;
    logic [2:0]             bit_cnt;
    logic [2:0]             bit_cnt_n;
    logic [7:0]             shreg;
    logic [7:0]             shreg_n;
    logic                   rw;
    logic                   rw_n;
    logic                   sda_oe;
    logic                   sda_oe_n;
    logic                   rd_pend;
    logic                   rd_pend_n;
    logic                   busy_n;
    logic [7:0]             rx_data_n;
    logic                   rx_data_valid_n;
    logic                   tx_data_req_n;
    logic                   error_slave_n;
    logic                   load_c;
    logic [7:0]             shift_in_c;
    logic [7:0]             load_byte_c;

    // Open-drain pad: pull low or release
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Input synchronizers plus one edge-detect stage
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise_c = scl_s & ~scl_prev;
    assign scl_fall_c = ~scl_s & scl_prev;
    assign start_c    = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_c     = scl_s & scl_prev & ~sda_prev & sda_s;
    assign shift_in_c = {shreg[6:0], sda_s};
    assign load_byte_c = tx_data_valid ? tx_data : 8'hFF;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            shreg         <= 8'h00;
            rw            <= 1'b0;
            sda_oe        <= 1'b0;
            rd_pend       <= 1'b0;
            busy          <= 1'b0;
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
            tx_data_req   <= 1'b0;
            error_slave   <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            shreg         <= shreg_n;
            rw            <= rw_n;
            sda_oe        <= sda_oe_n;
            rd_pend       <= rd_pend_n;
            busy          <= busy_n;
            rx_data       <= rx_data_n;
            rx_data_valid <= rx_data_valid_n;
            tx_data_req   <= tx_data_req_n;
            error_slave   <= error_slave_n;
        end
    end

    // Next-state and output decode; STOP beats START beats bit events
    always_comb begin
        state_n         = state;
        bit_cnt_n       = bit_cnt;
        shreg_n         = shreg;
        rw_n            = rw;
        sda_oe_n        = sda_oe;
        rd_pend_n       = rd_pend;
        busy_n          = busy;
        rx_data_n       = rx_data;
        rx_data_valid_n = 1'b0;
        tx_data_req_n   = 1'b0;
        error_slave_n   = 1'b0;
        load_c          = 1'b0;

        case (state)
            ADDR: begin
                if (scl_rise_c) begin
                    shreg_n   = shift_in_c;
                    bit_cnt_n = 3'(bit_cnt + 3'd1);
                    if (bit_cnt == 3'd7) begin
                        if (shift_in_c[7:1] == SLAVE_ADDR) begin
                            rw_n          = shift_in_c[0];
                            busy_n        = 1'b1;
                            tx_data_req_n = shift_in_c[0];
                            state_n       = ADDR_ACK;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = IGNORE;
                        end
                    end
                end
            end
            ADDR_ACK, WR_ACK: begin
                // First fall starts the ACK pull-down, second fall ends it
                if (scl_fall_c) begin
                    if (!sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else begin
                        sda_oe_n = 1'b0;
                        if (state == WR_ACK || !rw) begin
                            state_n = WR_DATA;
                        end else begin
                            state_n = RD_DATA;
                            load_c  = 1'b1;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (scl_rise_c) begin
                    shreg_n   = shift_in_c;
                    bit_cnt_n = 3'(bit_cnt + 3'd1);
                    if (bit_cnt == 3'd7) begin
                        rx_data_n       = shift_in_c;
                        rx_data_valid_n = 1'b1;
                        state_n         = WR_ACK;
                    end
                end
            end
            RD_DATA: begin
                if (scl_rise_c) begin
                    bit_cnt_n = 3'(bit_cnt + 3'd1);
                end else if (scl_fall_c) begin
                    if (rd_pend) begin
                        load_c    = 1'b1;
                        rd_pend_n = 1'b0;
                    end else if (bit_cnt == 3'd0) begin
                        sda_oe_n = 1'b0;
                        state_n  = RD_ACK;
                    end else begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        sda_oe_n = ~shreg[6];
                    end
                end
            end
            RD_ACK: begin
                if (scl_rise_c) begin
                    if (!sda_s) begin
                        tx_data_req_n = 1'b1;
                        rd_pend_n     = 1'b1;
                        state_n       = RD_DATA;
                    end else begin
                        state_n = IGNORE;
                    end
                end
            end
            IGNORE: begin
                sda_oe_n = 1'b0;
            end
            default: begin
                sda_oe_n = 1'b0;
            end
        endcase

        // Read byte load at the fall that closes an ACK slot
        if (load_c) begin
            shreg_n       = load_byte_c;
            sda_oe_n      = ~load_byte_c[7];
            bit_cnt_n     = 3'd0;
            error_slave_n = ~tx_data_valid;
        end

        if (stop_c) begin
            state_n         = IDLE;
            sda_oe_n        = 1'b0;
            busy_n          = 1'b0;
            rd_pend_n       = 1'b0;
            rx_data_n       = rx_data;
            rx_data_valid_n = 1'b0;
            tx_data_req_n   = 1'b0;
            error_slave_n   = 1'b0;
        end else if (start_c) begin
            state_n         = ADDR;
            bit_cnt_n       = 3'd0;
            sda_oe_n        = 1'b0;
            rd_pend_n       = 1'b0;
            rx_data_n       = rx_data;
            rx_data_valid_n = 1'b0;
            tx_data_req_n   = 1'b0;
            error_slave_n   = 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged master drives directed frames; written
// bytes are checked by a scoreboard monitor, bus-level results inline.
module tb_i2c_slave;

    localparam int Q = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_low;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_req;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       busy;
    logic       error_slave;
    wire        sda;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .scl           (scl),
        .sda           (sda),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_req   (tx_data_req),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .busy          (busy),
        .error_slave   (error_slave)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         req_cnt = 0;
    int         err_cnt = 0;
    int         rxv_cnt = 0;
    logic [7:0] rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx_data_valid pulse pops one expected byte
    initial begin
        forever begin
            @(negedge clk);
            if (rx_data_valid === 1'b1) begin
                rxv_cnt++;
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h expected no pulse", rx_data);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
                end
            end
            if (tx_data_req === 1'b1) req_cnt++;
            if (error_slave === 1'b1) err_cnt++;
        end
    end

    task automatic wbit(input logic b);
        sda_low = ~b;
        #(Q); scl = 1'b1;
        #(2*Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic rbit(output logic b);
        sda_low = 1'b0;
        #(Q); scl = 1'b1;
        #(Q); b = (sda !== 1'b0);
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic nack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(nack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack);
    endtask

    task automatic bus_start();
        sda_low = 1'b1;
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic bus_rstart();
        sda_low = 1'b0;
        #(Q); scl = 1'b1;
        #(Q); sda_low = 1'b1;
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1;
        #(Q); scl = 1'b1;
        #(Q); sda_low = 1'b0;
        #(2*Q);
    endtask

    initial begin
        logic       nack;
        logic [7:0] d;
        logic [7:0] addr_w;

        rst           = 1'b1;
        scl           = 1'b1;
        sda_low       = 1'b0;
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_data_valid), 32'h0);
        check("rst_tx_req", 32'(tx_data_req), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_error", 32'(error_slave), 32'h0);
        check("rst_sda", 32'(sda), 32'h1);

        // Write 8'hA5 to 0x50
        bus_start();
        wbyte(8'hA0, nack);
        check("t1_addr_ack", 32'(nack), 32'h0);
        check("t1_busy_mid", 32'(busy), 32'h1);
        rx_q.push_back(8'hA5);
        wbyte(8'hA5, nack);
        check("t1_data_ack", 32'(nack), 32'h0);
        bus_stop();
        check("t1_busy_after", 32'(busy), 32'h0);
        check("t1_rxv_count", 32'(rxv_cnt), 32'd1);

        // Wrong address 0x51: never driven
        bus_start();
        wbyte(8'hA2, nack);
        check("t2_addr_nack", 32'(nack), 32'h1);
        check("t2_busy", 32'(busy), 32'h0);
        wbyte(8'h3C, nack);
        check("t2_data_nack", 32'(nack), 32'h1);
        bus_stop();
        check("t2_rxv_count", 32'(rxv_cnt), 32'd1);

        // Two-byte read: 3C (ACK) then C3 (NACK)
        tx_data       = 8'h3C;
        tx_data_valid = 1'b1;
        bus_start();
        wbyte(8'hA1, nack);
        check("t3_addr_ack", 32'(nack), 32'h0);
        check("t3_busy", 32'(busy), 32'h1);
        tx_data = 8'hC3;
        rbyte(d, 1'b0);
        check("t3_byte0", 32'(d), 32'h3C);
        rbyte(d, 1'b1);
        check("t3_byte1", 32'(d), 32'hC3);
        check("t3_sda_released", 32'(sda), 32'h1);
        bus_stop();
        check("t3_req_count", 32'(req_cnt), 32'd2);
        check("t3_busy_after", 32'(busy), 32'h0);

        // Write 11 then repeated START into a read
        bus_start();
        wbyte(8'hA0, nack);
        check("t4_addr_ack", 32'(nack), 32'h0);
        rx_q.push_back(8'h11);
        wbyte(8'h11, nack);
        check("t4_data_ack", 32'(nack), 32'h0);
        tx_data = 8'h96;
        bus_rstart();
        wbyte(8'hA1, nack);
        check("t4_sr_ack", 32'(nack), 32'h0);
        check("t4_rx_data", 32'(rx_data), 32'h11);
        rbyte(d, 1'b1);
        check("t4_read", 32'(d), 32'h96);
        bus_stop();
        check("t4_req_count", 32'(req_cnt), 32'd3);

        // Read underflow
        tx_data_valid = 1'b0;
        bus_start();
        wbyte(8'hA1, nack);
        check("t5_addr_ack", 32'(nack), 32'h0);
        rbyte(d, 1'b1);
        check("t5_read_ff", 32'(d), 32'hFF);
        bus_stop();
        check("t5_err_count", 32'(err_cnt), 32'd1);
        check("t5_req_count", 32'(req_cnt), 32'd4);

        // Reset while the slave holds the address ACK low
        tx_data_valid = 1'b1;
        bus_start();
        addr_w = 8'hA0;
        for (int i = 7; i >= 0; i--) wbit(addr_w[i]);
        sda_low = 1'b0;
        #(Q); scl = 1'b1;
        #(Q);
        check("t6_ack_low", 32'(sda), 32'h0);
        check("t6_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_sda_rel", 32'(sda), 32'h1);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_rx_data", 32'(rx_data), 32'h00);
        check("t6_rx_valid", 32'(rx_data_valid), 32'h0);
        check("t6_tx_req", 32'(tx_data_req), 32'h0);
        check("t6_error", 32'(error_slave), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #(Q); scl = 1'b0;
        #(Q);
        bus_stop();

        // Normal frame after reset
        bus_start();
        wbyte(8'hA0, nack);
        check("t7_addr_ack", 32'(nack), 32'h0);
        rx_q.push_back(8'h5A);
        wbyte(8'h5A, nack);
        check("t7_data_ack", 32'(nack), 32'h0);
        bus_stop();
        check("t7_busy_after", 32'(busy), 32'h0);

        #(4*Q);
        check("end_rx_queue_empty", 32'(rx_q.size()), 32'd0);
        check("end_rxv_count", 32'(rxv_cnt), 32'd3);
        check("end_req_count", 32'(req_cnt), 32'd4);
        check("end_err_count", 32'(err_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
